// File: rtl/mem_access_unit_if.sv
// Bus bundle of the MEM-stage load/store unit: EX/MEM-side request, data-memory
// handshake and status. The unit connects through the slave modport.
interface mem_access_unit_if;
  logic        IN_MEM_READ;
  logic        IN_MEM_WRITE;
  logic [2:0]  IN_FUNCT3;
  logic [31:0] IN_ADDRESS;
  logic [31:0] IN_WRITE_DATA;
  logic [31:0] OUT_READ_DATA;
  logic        BUSYWAIT;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_ADDRESS;
  logic [31:0] DMEM_WRITE_DATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic [31:0] DMEM_READ_DATA;
  logic        DMEM_BUSYWAIT;
  logic        OUT_TIMEOUT;
  logic        OUT_MISALIGNED;
  logic [1:0]  dbg_state;

  modport slave (
    input  IN_MEM_READ, IN_MEM_WRITE, IN_FUNCT3, IN_ADDRESS, IN_WRITE_DATA,
    input  DMEM_READ_DATA, DMEM_BUSYWAIT,
    output OUT_READ_DATA, BUSYWAIT, DMEM_READ, DMEM_WRITE, DMEM_ADDRESS,
    output DMEM_WRITE_DATA, DMEM_BYTE_EN, OUT_TIMEOUT, OUT_MISALIGNED, dbg_state
  );

  modport master (
    output IN_MEM_READ, IN_MEM_WRITE, IN_FUNCT3, IN_ADDRESS, IN_WRITE_DATA,
    output DMEM_READ_DATA, DMEM_BUSYWAIT,
    input  OUT_READ_DATA, BUSYWAIT, DMEM_READ, DMEM_WRITE, DMEM_ADDRESS,
    input  DMEM_WRITE_DATA, DMEM_BYTE_EN, OUT_TIMEOUT, OUT_MISALIGNED, dbg_state
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE/ACCESS/DONE handshake with data memory, lane
// steering and load extension. Optional macro MISALIGN_TRAP_EN traps misaligned H/W accesses.
//
// Handshake: BUSYWAIT=1 stalls the pipeline (asserted combinationally in IDLE when a
// request is present, and throughout ACCESS); memory completes an access at the first
// ACCESS-cycle posedge with DMEM_BUSYWAIT=0; DONE is a single non-stalling cycle.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_access_unit_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [31:0] dmem_address_q, dmem_address_d;
  logic [31:0] dmem_write_data_q, dmem_write_data_d;
  logic [3:0]  dmem_byte_en_q, dmem_byte_en_d;
  logic [31:0] read_data_q, read_data_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;

  logic        req;
  logic        mis_trap;
  logic [31:0] store_data;
  logic [3:0]  store_be;

  assign req = bus.IN_MEM_READ | bus.IN_MEM_WRITE;

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   load_ext = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  always_comb begin
    case (bus.IN_FUNCT3[1:0])
      2'b00: begin
        store_data = {4{bus.IN_WRITE_DATA[7:0]}};
        store_be   = 4'b0001 << bus.IN_ADDRESS[1:0];
      end
      2'b01: begin
        store_data = {2{bus.IN_WRITE_DATA[15:0]}};
        store_be   = bus.IN_ADDRESS[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = bus.IN_WRITE_DATA;
        store_be   = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  always_comb begin
    case (bus.IN_FUNCT3[1:0])
      2'b00:   mis_trap = 1'b0;
      2'b01:   mis_trap = bus.IN_ADDRESS[0];
      default: mis_trap = |bus.IN_ADDRESS[1:0];
    endcase
  end
`else
  assign mis_trap = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    dmem_read_d       = dmem_read_q;
    dmem_write_d      = dmem_write_q;
    dmem_address_d    = dmem_address_q;
    dmem_write_data_d = dmem_write_data_q;
    dmem_byte_en_d    = dmem_byte_en_q;
    read_data_d       = read_data_q;
    timeout_d         = timeout_q;
    funct3_d          = funct3_q;
    lane_d            = lane_q;
`ifdef MISALIGN_TRAP_EN
    misaligned_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          funct3_d = bus.IN_FUNCT3;
          lane_d   = bus.IN_ADDRESS[1:0];
          cnt_d    = 8'd0;
          if (mis_trap) begin
            // Trapped access skips memory entirely; loads see zero.
            state_d = S_DONE;
            if (!bus.IN_MEM_WRITE) read_data_d = 32'd0;
`ifdef MISALIGN_TRAP_EN
            misaligned_d = 1'b1;
`endif
          end else begin
            state_d           = S_ACCESS;
            dmem_address_d    = {bus.IN_ADDRESS[31:2], 2'b00};
            dmem_read_d       = ~bus.IN_MEM_WRITE;
            dmem_write_d      = bus.IN_MEM_WRITE;
            dmem_write_data_d = bus.IN_MEM_WRITE ? store_data : 32'd0;
            dmem_byte_en_d    = bus.IN_MEM_WRITE ? store_be : 4'b0000;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (!bus.DMEM_BUSYWAIT) begin
          state_d      = S_DONE;
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          if (dmem_read_q) read_data_d = load_ext(bus.DMEM_READ_DATA, funct3_q, lane_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_DONE;
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          timeout_d    = 1'b1;
          if (dmem_read_q) read_data_d = 32'd0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q           <= S_IDLE;
      cnt_q             <= 8'd0;
      dmem_read_q       <= 1'b0;
      dmem_write_q      <= 1'b0;
      dmem_address_q    <= 32'd0;
      dmem_write_data_q <= 32'd0;
      dmem_byte_en_q    <= 4'b0000;
      read_data_q       <= 32'd0;
      timeout_q         <= 1'b0;
      funct3_q          <= 3'd0;
      lane_q            <= 2'd0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q      <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      dmem_read_q       <= dmem_read_d;
      dmem_write_q      <= dmem_write_d;
      dmem_address_q    <= dmem_address_d;
      dmem_write_data_q <= dmem_write_data_d;
      dmem_byte_en_q    <= dmem_byte_en_d;
      read_data_q       <= read_data_d;
      timeout_q         <= timeout_d;
      funct3_q          <= funct3_d;
      lane_q            <= lane_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q      <= misaligned_d;
`endif
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign bus.OUT_MISALIGNED = misaligned_q;
`else
  assign bus.OUT_MISALIGNED = 1'b0;
`endif

  assign bus.BUSYWAIT        = ~RESET & (((state_q == S_IDLE) & req) | (state_q == S_ACCESS));
  assign bus.OUT_READ_DATA   = read_data_q;
  assign bus.DMEM_READ       = dmem_read_q;
  assign bus.DMEM_WRITE      = dmem_write_q;
  assign bus.DMEM_ADDRESS    = dmem_address_q;
  assign bus.DMEM_WRITE_DATA = dmem_write_data_q;
  assign bus.DMEM_BYTE_EN    = dmem_byte_en_q;
  assign bus.OUT_TIMEOUT     = timeout_q;
  assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, timeout, async reset and the
// misalignment trap (expectations follow MISALIGN_TRAP_EN when defined).
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  int          r_stalls, r_acc, r_mis;
  logic        r_rd, r_wr;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;

  localparam logic [31:0] MEM_WORD = 32'h8011_2233;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.IN_MEM_READ   = 1'b0;
    bus.IN_MEM_WRITE  = 1'b0;
    bus.IN_FUNCT3     = 3'd0;
    bus.IN_ADDRESS    = 32'd0;
    bus.IN_WRITE_DATA = 32'd0;
  endtask

  // Issues one access and plays memory: DMEM_BUSYWAIT stays high for wait_n ACCESS
  // cycles. Records stall cycles, ACCESS cycles, strobes/bus seen and misaligned pulses.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int wait_n);
    bit done;
    done = 0;
    r_stalls = 0; r_acc = 0; r_mis = 0;
    r_rd = 1'b0; r_wr = 1'b0; r_addr = 32'd0; r_wdata = 32'd0; r_be = 4'd0;
    @(negedge clk);
    bus.IN_MEM_READ    = rd;
    bus.IN_MEM_WRITE   = wr;
    bus.IN_FUNCT3      = f3;
    bus.IN_ADDRESS     = addr;
    bus.IN_WRITE_DATA  = wdata;
    bus.DMEM_READ_DATA = MEM_WORD;
    bus.DMEM_BUSYWAIT  = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (bus.OUT_MISALIGNED) r_mis++;
      if (bus.BUSYWAIT) begin
        r_stalls++;
        if (bus.DMEM_READ || bus.DMEM_WRITE) begin
          r_rd    = bus.DMEM_READ;
          r_wr    = bus.DMEM_WRITE;
          r_addr  = bus.DMEM_ADDRESS;
          r_wdata = bus.DMEM_WRITE_DATA;
          r_be    = bus.DMEM_BYTE_EN;
          bus.DMEM_BUSYWAIT = (r_acc < wait_n);
          r_acc++;
        end
        @(negedge clk);
      end else begin
        done = 1;
        check("done_strobes_low", {30'd0, bus.DMEM_READ, bus.DMEM_WRITE}, 32'd0);
        idle_inputs();
        bus.DMEM_BUSYWAIT = 1'b0;
      end
    end
    check("access_bound", {31'd0, done}, 32'd1);
    @(negedge clk);
    #1;
    if (bus.OUT_MISALIGNED) r_mis++;
    check("back_to_idle", {30'd0, bus.dbg_state}, 32'd0);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp_data, input int wait_n);
    exp_q.push_back(exp_data);
    do_access(1'b1, 1'b0, f3, addr, 32'd0, wait_n);
    check({tag, "_data"}, bus.OUT_READ_DATA, exp_q.pop_front());
    check({tag, "_stalls"}, 32'(r_stalls), 32'(2 + wait_n));
    check({tag, "_rd"}, {31'd0, r_rd}, 32'd1);
    check({tag, "_addr"}, r_addr, {addr[31:2], 2'b00});
    check({tag, "_be"}, {28'd0, r_be}, 32'd0);
  endtask

  task automatic store(input string tag, input logic rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    do_access(rd, 1'b1, f3, addr, wdata, 0);
    check({tag, "_wr"}, {30'd0, r_rd, r_wr}, 32'd1);
    check({tag, "_addr"}, r_addr, {addr[31:2], 2'b00});
    check({tag, "_wdata"}, r_wdata, exp_wdata);
    check({tag, "_be"}, {28'd0, r_be}, {28'd0, exp_be});
    check({tag, "_stalls"}, 32'(r_stalls), 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    bus.DMEM_READ_DATA = 32'd0;
    bus.DMEM_BUSYWAIT  = 1'b0;
    #1;
    check("rst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    check("rst_strobes", {30'd0, bus.DMEM_READ, bus.DMEM_WRITE}, 32'd0);
    check("rst_rdata", bus.OUT_READ_DATA, 32'd0);
    check("rst_timeout", {31'd0, bus.OUT_TIMEOUT}, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    load("lb",   3'b000, 32'h0000_0103, 32'hFFFF_FF80, 0);
    load("lhu",  3'b101, 32'h0000_0102, 32'h0000_8011, 0);
    load("lh",   3'b001, 32'h0000_0102, 32'hFFFF_8011, 1);
    load("lbu",  3'b100, 32'h0000_0100, 32'h0000_0033, 0);
    load("lw",   3'b010, 32'h0000_0100, 32'h8011_2233, 2);
    load("undef_f3", 3'b011, 32'h0000_0201, 32'h8011_2233, 0);

    store("sb", 1'b0, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b0010);
    store("sh", 1'b0, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100);
    store("sw_rdwr", 1'b1, 3'b010, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678, 4'b1111);
    check("sw_keeps_rdata", bus.OUT_READ_DATA, 32'h8011_2233);

    // Timeout: memory never answers, so four ACCESS cycles then abort.
    check("pre_timeout_flag", {31'd0, bus.OUT_TIMEOUT}, 32'd0);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 1000);
    check("to_acc_cycles", 32'(r_acc), 32'd4);
    check("to_stalls", 32'(r_stalls), 32'd5);
    check("to_rdata", bus.OUT_READ_DATA, 32'd0);
    check("to_flag", {31'd0, bus.OUT_TIMEOUT}, 32'd1);
    load("post_to_lbu", 3'b100, 32'h0000_0101, 32'h0000_0022, 0);
    check("to_sticky", {31'd0, bus.OUT_TIMEOUT}, 32'd1);

    // Async reset in the middle of an ACCESS.
    @(negedge clk);
    bus.IN_MEM_READ   = 1'b1;
    bus.IN_FUNCT3     = 3'b010;
    bus.IN_ADDRESS    = 32'h0000_0108;
    bus.DMEM_BUSYWAIT = 1'b1;
    @(negedge clk);
    #1;
    check("mid_access_rd", {31'd0, bus.DMEM_READ}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_rd", {31'd0, bus.DMEM_READ}, 32'd0);
    check("arst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    check("arst_state", {30'd0, bus.dbg_state}, 32'd0);
    check("arst_rdata", bus.OUT_READ_DATA, 32'd0);
    check("arst_timeout", {31'd0, bus.OUT_TIMEOUT}, 32'd0);
    check("arst_addr", bus.DMEM_ADDRESS, 32'd0);
    idle_inputs();
    bus.DMEM_BUSYWAIT = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Misaligned word load.
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 0);
`ifdef MISALIGN_TRAP_EN
    check("mis_stalls", 32'(r_stalls), 32'd1);
    check("mis_no_strobe", 32'(r_acc), 32'd0);
    check("mis_pulses", 32'(r_mis), 32'd1);
    check("mis_rdata", bus.OUT_READ_DATA, 32'd0);
`else
    check("mis_stalls", 32'(r_stalls), 32'd2);
    check("mis_addr", r_addr, 32'h0000_0100);
    check("mis_pulses", 32'(r_mis), 32'd0);
    check("mis_rdata", bus.OUT_READ_DATA, 32'h8011_2233);
`endif

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
